// File: rtl/tx_word_sched.sv
// Two-requester word scheduler feeding a byte-wide UART transmitter.
// Round-robin arbitration picks a word, which is then sent one byte per start/done round trip.
module tx_word_sched #(
    parameter int NBYTES    = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iValid0,
    input  logic [8*NBYTES-1:0]   iData0,
    output logic                  oReady0,
    input  logic                  iValid1,
    input  logic [8*NBYTES-1:0]   iData1,
    output logic                  oReady1,
    output logic                  oTxStart,
    output logic [7:0]            oTxByte,
    input  logic                  iTxDone,
    output logic                  oBusy,
    output logic                  oSrc
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES) + 1;

    typedef enum logic [1:0] {
        sIDLE = 2'd0,
        sSEND = 2'd1,
        sWAIT = 2'd2
    } state_t;

    state_t          rState;
    state_t          wNext;
    logic            rLast;
    logic            rSrc;
    logic [CW-1:0]   rCnt;
    logic [W-1:0]    rWord;
    logic [7:0]      rTxByte;

    logic            wGrant0;
    logic            wGrant1;
    logic            wLastByte;
    logic [CW-1:0]   wNextCnt;
    logic [W-1:0]    wSelData;

    function automatic logic [7:0] pickByte(input logic [W-1:0] word, input logic [CW-1:0] k);
        int shift;
        if (MSB_FIRST != 0) shift = 8 * (NBYTES - 1 - int'(k));
        else                shift = 8 * int'(k);
        return 8'(word >> shift);
    endfunction

    assign wLastByte = (rCnt == CW'(NBYTES - 1));
    assign wNextCnt  = rCnt + CW'(1);
    assign wSelData  = wGrant1 ? iData1 : iData0;

    // On a tie the requester that was not served last wins.
    always_comb begin
        wGrant0 = 1'b0;
        wGrant1 = 1'b0;
        if (iRstN && rState == sIDLE) begin
            if (iValid0 && iValid1) begin
                wGrant0 = rLast;
                wGrant1 = !rLast;
            end else begin
                wGrant0 = iValid0;
                wGrant1 = iValid1;
            end
        end
    end

    always_comb begin
        wNext = sIDLE;
        case (rState)
            sIDLE:   wNext = (wGrant0 || wGrant1) ? sSEND : sIDLE;
            sSEND:   wNext = sWAIT;
            sWAIT: begin
                if (iTxDone) wNext = wLastByte ? sIDLE : sSEND;
                else         wNext = sWAIT;
            end
            default: wNext = sIDLE;
        endcase
    end

    // The outgoing byte is loaded on the same edge that enters sSEND, so it is valid with the start pulse.
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            rState  <= sIDLE;
            rLast   <= 1'b1;
            rSrc    <= 1'b0;
            rCnt    <= '0;
            rWord   <= '0;
            rTxByte <= 8'h00;
        end else begin
            rState <= wNext;
            if (wGrant0 || wGrant1) begin
                rWord   <= wSelData;
                rTxByte <= pickByte(wSelData, '0);
                rCnt    <= '0;
                rSrc    <= wGrant1;
                rLast   <= wGrant1;
            end else if (rState == sWAIT && iTxDone && !wLastByte) begin
                rCnt    <= wNextCnt;
                rTxByte <= pickByte(rWord, wNextCnt);
            end
        end
    end

    assign oReady0  = wGrant0;
    assign oReady1  = wGrant1;
    assign oTxStart = (rState == sSEND);
    assign oTxByte  = rTxByte;
    assign oBusy    = (rState != sIDLE);
    assign oSrc     = rSrc;

endmodule

// File: tb/tb_tx_word_sched.sv
// Directed bench for tx_word_sched: one MSB-first and one LSB-first instance, UART done pulses
// returned three cycles after each start.
module tb_tx_word_sched;

    logic        iClk;
    logic        iRstN;

    logic        validA0, validA1, readyA0, readyA1, startA, doneA, busyA, srcA;
    logic [31:0] dataA0, dataA1;
    logic [7:0]  byteA;

    logic        validB0, validB1, readyB0, readyB1, startB, doneB, busyB, srcB;
    logic [31:0] dataB0, dataB1;
    logic [7:0]  byteB;

    int errorCount = 0;
    int checkCount = 0;

    tx_word_sched #(.NBYTES(4), .MSB_FIRST(1)) dutA (
        .iClk(iClk), .iRstN(iRstN),
        .iValid0(validA0), .iData0(dataA0), .oReady0(readyA0),
        .iValid1(validA1), .iData1(dataA1), .oReady1(readyA1),
        .oTxStart(startA), .oTxByte(byteA), .iTxDone(doneA),
        .oBusy(busyA), .oSrc(srcA)
    );

    tx_word_sched #(.NBYTES(4), .MSB_FIRST(0)) dutB (
        .iClk(iClk), .iRstN(iRstN),
        .iValid0(validB0), .iData0(dataB0), .oReady0(readyB0),
        .iValid1(validB1), .iData1(dataB1), .oReady1(readyB1),
        .oTxStart(startB), .oTxByte(byteB), .iTxDone(doneB),
        .oBusy(busyB), .oSrc(srcB)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic setDone(input bit useB, input logic value);
        if (useB) doneB = value;
        else      doneA = value;
    endtask

    // Presents one word on a single requester and checks it is the one granted.
    task automatic applyStimulus(input bit useB, input bit req, input logic [31:0] data, input string tag);
        if (useB) begin
            if (req) begin validB1 = 1'b1; dataB1 = data; end
            else     begin validB0 = 1'b1; dataB0 = data; end
        end else begin
            if (req) begin validA1 = 1'b1; dataA1 = data; end
            else     begin validA0 = 1'b1; dataA0 = data; end
        end
        #1;
        checkOutput({tag, "-ready0"}, useB ? readyB0 : readyA0, !req);
        checkOutput({tag, "-ready1"}, useB ? readyB1 : readyA1, req);
        tick();
        validA0 = 1'b0; validA1 = 1'b0; validB0 = 1'b0; validB1 = 1'b0;
    endtask

    // Entered in the sSEND cycle of byte firstIdx; expOrder lists the bytes in send order from the top.
    task automatic serviceWord(input bit useB, input logic [31:0] expOrder, input int firstIdx,
                               input bit expSrc, input string tag);
        logic [31:0] tmp;
        for (int k = firstIdx; k < 4; k++) begin
            tmp = expOrder >> (8 * (3 - k));
            checkOutput({tag, "-start"}, useB ? startB : startA, 1);
            checkOutput({tag, "-byte"},  useB ? byteB : byteA, tmp[7:0]);
            checkOutput({tag, "-src"},   useB ? srcB : srcA, expSrc);
            checkOutput({tag, "-busy"},  useB ? busyB : busyA, 1);
            checkOutput({tag, "-noready"}, useB ? (readyB0 | readyB1) : (readyA0 | readyA1), 0);
            tick();
            checkOutput({tag, "-pulse1"}, useB ? startB : startA, 0);
            checkOutput({tag, "-hold"},   useB ? byteB : byteA, tmp[7:0]);
            tick();
            tick();
            setDone(useB, 1'b1);
            tick();
            setDone(useB, 1'b0);
        end
        checkOutput({tag, "-idle"}, useB ? busyB : busyA, 0);
        checkOutput({tag, "-idlestart"}, useB ? startB : startA, 0);
    endtask

    initial begin
        iRstN = 1'b0;
        validA0 = 1'b1; validA1 = 1'b0; dataA0 = '0; dataA1 = '0; doneA = 1'b0;
        validB0 = 1'b0; validB1 = 1'b1; dataB0 = '0; dataB1 = '0; doneB = 1'b0;

        // Reset state, with requests pending to confirm readies stay low.
        tick();
        tick();
        checkOutput("rst-readyA0", readyA0, 0);
        checkOutput("rst-readyB1", readyB1, 0);
        checkOutput("rst-busy",    busyA, 0);
        checkOutput("rst-start",   startA, 0);
        checkOutput("rst-byte",    byteA, 8'h00);
        checkOutput("rst-src",     srcA, 0);
        validA0 = 1'b0; validB1 = 1'b0;
        iRstN = 1'b1;

        // Single word, MSB first.
        applyStimulus(1'b0, 1'b0, 32'hDEADBEEF, "single");
        serviceWord(1'b0, 32'hDEADBEEF, 0, 1'b0, "single");

        // LSB-first instance, requester 1.
        applyStimulus(1'b1, 1'b1, 32'h11223344, "lsb");
        serviceWord(1'b1, 32'h44332211, 0, 1'b1, "lsb");

        // Back-to-back: requester 0 keeps valid high across two words.
        validA0 = 1'b1; dataA0 = 32'h55667788;
        #1;
        checkOutput("b2b-hs1", readyA0, 1);
        tick();
        serviceWord(1'b0, 32'h55667788, 0, 1'b0, "b2b1");
        dataA0 = 32'h99AABBCC;
        #1;
        checkOutput("b2b-hs2", readyA0, 1);
        tick();
        validA0 = 1'b0;
        serviceWord(1'b0, 32'h99AABBCC, 0, 1'b0, "b2b2");

        // Spurious done pulses in sIDLE and sSEND.
        doneA = 1'b1;
        tick();
        doneA = 1'b0;
        checkOutput("spur-idlebusy",  busyA, 0);
        checkOutput("spur-idlestart", startA, 0);
        validA0 = 1'b1; dataA0 = 32'hCAFEF00D; doneA = 1'b1;
        #1;
        checkOutput("spur-ready", readyA0, 1);
        tick();
        validA0 = 1'b0;
        checkOutput("spur-start0", startA, 1);
        checkOutput("spur-byte0",  byteA, 8'hCA);
        tick();
        doneA = 1'b0;
        checkOutput("spur-nostart", startA, 0);
        checkOutput("spur-busy",    busyA, 1);
        checkOutput("spur-keep",    byteA, 8'hCA);
        tick();
        tick();
        doneA = 1'b1;
        tick();
        doneA = 1'b0;
        serviceWord(1'b0, 32'hCAFEF00D, 1, 1'b0, "spur");

        // Reset in the middle of a word, then a fresh word.
        applyStimulus(1'b0, 1'b0, 32'hAABBCCDD, "abort");
        checkOutput("abort-byte0", byteA, 8'hAA);
        tick();
        tick();
        tick();
        doneA = 1'b1;
        tick();
        doneA = 1'b0;
        checkOutput("abort-start1", startA, 1);
        checkOutput("abort-byte1",  byteA, 8'hBB);
        tick();
        iRstN = 1'b0;
        tick();
        iRstN = 1'b1;
        checkOutput("abort-start", startA, 0);
        checkOutput("abort-busy",  busyA, 0);
        checkOutput("abort-byte",  byteA, 8'h00);
        checkOutput("abort-src",   srcA, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("abort-noresend", startA, 0);
        end
        applyStimulus(1'b0, 1'b0, 32'h01020304, "post");
        serviceWord(1'b0, 32'h01020304, 0, 1'b0, "post");

        // Tie and fairness after a clean reset: requester 0 wins first, then strict alternation.
        iRstN = 1'b0;
        tick();
        iRstN = 1'b1;
        validA0 = 1'b1; dataA0 = 32'hA0A0A0A0;
        validA1 = 1'b1; dataA1 = 32'hB0B0B0B0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("tie-ready0", readyA0, (i % 2) == 0);
            checkOutput("tie-ready1", readyA1, (i % 2) == 1);
            tick();
            serviceWord(1'b0, ((i % 2) == 0) ? 32'hA0A0A0A0 : 32'hB0B0B0B0, 0, (i % 2) == 1, "tie");
        end
        validA0 = 1'b0; validA1 = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tx_word_sched.md
TX_WORD_SCHED -- requirements
Module: tx_word_sched

Interface -- parameters
REQ-001 The block SHALL have parameter NBYTES, default 4, giving the number of bytes serialized per word (legal range 1..8).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = most-significant byte sent first, 0 = least-significant byte sent first.

Interface -- ports
REQ-003 The port iClk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-004 The port iRstN SHALL be an input, 1 bit wide: synchronous, active-low reset.
REQ-005 The port iValid0 SHALL be an input, 1 bit wide: requester 0 word valid.
REQ-006 The port iData0 SHALL be an input, 8*NBYTES bits wide: requester 0 word.
REQ-007 The port oReady0 SHALL be an output, 1 bit wide: requester 0 word accepted this cycle when iValid0 is also 1.
REQ-008 The port iValid1 SHALL be an input, 1 bit wide: requester 1 word valid.
REQ-009 The port iData1 SHALL be an input, 8*NBYTES bits wide: requester 1 word.
REQ-010 The port oReady1 SHALL be an output, 1 bit wide: requester 1 word accepted this cycle when iValid1 is also 1.
REQ-011 The port oTxStart SHALL be an output, 1 bit wide: one-cycle start pulse to the UART transmitter.
REQ-012 The port oTxByte SHALL be an output, 8 bits wide: byte presented to the UART transmitter.
REQ-013 The port iTxDone SHALL be an input, 1 bit wide: one-cycle pulse from the UART transmitter when its stop bit completes.
REQ-014 The port oBusy SHALL be an output, 1 bit wide: 1 whenever a word is in flight, i.e. any state other than sIDLE.
REQ-015 The port oSrc SHALL be an output, 1 bit wide: index of the requester whose word is in flight.

Function
REQ-016 The FSM SHALL have exactly three states: sIDLE, sSEND and sWAIT.
REQ-017 Arbitration in sIDLE SHALL be combinational and round-robin, using registered pointer rLast = index of the last granted requester:
  - only one iValid high -> that requester is granted;
  - both high -> the requester != rLast is granted;
  - neither high -> no grant.
REQ-018 oReadyN SHALL be 1 only in sIDLE and only for the granted requester; at most one oReady SHALL be high in any cycle.
REQ-019 On a handshake (iValidN && oReadyN) in cycle C, the block SHALL:
  - capture iDataN into the word register;
  - set the byte counter to 0;
  - set oSrc = N and rLast = N;
  - enter sSEND in cycle C+1.
REQ-020 In sSEND, oTxStart SHALL be 1 for exactly that one cycle, and the next state SHALL be sWAIT.
REQ-021 oTxByte SHALL be registered and SHALL be valid from the sSEND cycle, held stable through all of sWAIT.
  - MSB_FIRST=1: byte k is word[8*(NBYTES-k)-1 -: 8].
  - MSB_FIRST=0: byte k is word[8*k+7 -: 8].
REQ-022 In sWAIT, iTxDone SHALL be acted on as follows:
  - counter < NBYTES-1 -> increment the counter and return to sSEND in the next cycle;
  - counter == NBYTES-1 -> go to sIDLE.
REQ-023 Latency SHALL be: handshake in cycle C -> first oTxStart at C+1; iTxDone in cycle M -> next oTxStart at M+1.
REQ-024 After the last iTxDone of a word, the block SHALL reach sIDLE in the next cycle and SHALL accept a new word there; there SHALL be no dead cycles.
REQ-025 iTxDone SHALL be ignored in sIDLE and in sSEND.
REQ-026 iValid and iData changes SHALL be ignored outside sIDLE; a pending requester SHALL simply wait.
REQ-027 The byte counter SHALL be $clog2(NBYTES)+1 bits wide, and SHALL never wrap within a word.
REQ-028 Unreachable state encodings SHALL return to sIDLE with oTxStart=0.

Reset
REQ-029 While iRstN=0 at a rising edge, the block SHALL set:
  - state = sIDLE;
  - oTxStart = 0;
  - oTxByte = 8'h00;
  - oBusy = 0;
  - oSrc = 0;
  - byte counter = 0;
  - word register = 0;
  - rLast = 1, so requester 0 wins the first tie.
REQ-030 Both oReady0 and oReady1 SHALL be 0 during any cycle in which iRstN=0.
REQ-031 A reset asserted mid-word SHALL abort the word with no further oTxStart; the partial word SHALL be discarded and not resent.

Verification
REQ-032 Single word: NBYTES=4, MSB_FIRST=1, iData0=32'hDEADBEEF, done pulse returned 3 cycles after each start -> oTxStart pulses carry DE, AD, BE, EF in order; oBusy falls 1 cycle after the 4th iTxDone.
REQ-033 Byte order: MSB_FIRST=0, iData1=32'h11223344 -> bytes 44, 33, 22, 11; oSrc=1 throughout.
REQ-034 Tie and fairness: both valid continuously with A=32'hA0A0A0A0, B=32'hB0B0B0B0 -> grant order 0,1,0,1; no requester is granted twice in a row while the other waits.
REQ-035 Spurious done: an iTxDone pulse in sIDLE and in sSEND -> no state change and no extra oTxStart; the byte count is unaffected.
REQ-036 Reset mid-word: iRstN=0 for 1 cycle after the 2nd byte's start -> next cycle sIDLE, oTxStart=0, oBusy=0; after release a new word 32'h01020304 sends 01, 02, 03, 04.
REQ-037 Back-to-back timing: iValid0 held high with 2 words queued -> the second handshake occurs 1 cycle after the first word's final iTxDone, and the first oTxStart of word 2 occurs 1 cycle after that handshake.
